seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for an N-digit common-select 7-segment display. Holds a hex value per digit and drives one shared segment bus plus a one-hot digit-select bus. Cycles through digits with a programmable slot length and a blanking gap between digits to suppress ghosting. Accepts new display values over a valid/ready handshake and applies them only at frame boundaries so a frame never shows mixed old and new data.

## Interface

- `DIGITS`, default 4: number of digits, range 1..8.
- `CLK_DIV`, default 1000: clock cycles per digit slot, blank plus drive.
- `BLANK_CYCLES`, default 16: blank cycles at the start of each slot. Legal range is 1 ≤ BLANK_CYCLES < CLK_DIV.
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `enable`, input, 1: scan enable.
- `wr_valid`, input, 1: a new value is offered.
- `wr_ready`, output, 1: the controller can accept a value.
- `wr_data`, input, 4*DIGITS: nibble i is the value for digit i. Digit 0 is least significant.
- `wr_dp`, input, DIGITS: decimal point per digit.
- `seg_out`, output, 8: segment bus, active-high. Bit 7 is dp; bits 6..0 are segments a,b,c,d,e,f,g.
- `dig_sel`, output, DIGITS: one-hot digit select, active-high.
- `frame_done`, output, 1: one-cycle pulse at the end of each frame.

## Operation

- **Registers:** display register (data and dp), pending register with `pend_vld`, digit index, slot counter, state.
- **States:**
  - IDLE: `dig_sel`=0, `seg_out`=0.
  - BLANK: `dig_sel`=0, `seg_out`=0, lasts BLANK_CYCLES cycles.
  - DRIVE: `dig_sel`=1<<index, `seg_out`=decode(nibble[index]) | dp[index]<<7, lasts CLK_DIV−BLANK_CYCLES cycles.
- **Transitions:**
  - IDLE→BLANK when `enable`=1.
  - BLANK→DRIVE after its count expires.
  - DRIVE→BLANK after its count expires. The index increments, wrapping from DIGITS−1 to 0.
  - Any state→IDLE when `enable`=0. The index and counter clear; the pending and display registers are retained.
- **Decode:** 0–F map to 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47 in hex.
- **Handshake:**
  - `wr_ready` = !`pend_vld`.
  - An accept (`wr_valid`&&`wr_ready`) loads the pending register and sets `pend_vld`.
  - `wr_valid` may be held while `wr_ready`=0; the data must stay stable until accept.
- **Frame boundary:** the last DRIVE cycle of index DIGITS−1.
  - `frame_done` pulses during that cycle.
  - If `pend_vld`, the pending register copies into the display register and `pend_vld` clears.
  - The new value is visible from digit 0 of the next frame.
- **Accept at a boundary:** an accept in the boundary cycle while `pend_vld`=0 lands in pending and is applied at the next boundary.

## Timing

- **Reset values:** all outputs 0, except `wr_ready`=1 (`pend_vld`=0). Display register 0, so digits show "0" once enabled. State IDLE, index 0.
- **Registered outputs:** `seg_out`, `dig_sel` and `frame_done` are flops computed from next-state. Their value in cycle k reflects the state in cycle k.
- **Startup latency:** first BLANK cycle is 1 cycle after `enable` rises. First DRIVE is BLANK_CYCLES cycles later.
- **Frame period:** DIGITS*CLK_DIV cycles.
- **Enable drop:** outputs go to 0 in the cycle after `enable` falls. Re-enable restarts at index 0 with BLANK.
- **Reset mid-frame:** reset dominates and returns the block to its reset values. A pending value is lost.

## Configuration

- Macro: `SEG_SCAN_LEADING_ZERO_BLANK_EN`.
- **Defined:** digit i>0 is suppressed when its nibble and all higher nibbles are zero. A suppressed digit drives `seg_out`={dp[i],7'b0}, and `dig_sel` is still asserted. Digit 0 is never suppressed.
- **Undefined:** all digits always decode normally.

## Structure

- **Package `seg_pkg`:**
  - Segment pattern constants SEG_0..SEG_F and SEG_BLANK.
  - Bit-position constants SEG_DP_BIT=7, SEG_A_BIT=6 … SEG_G_BIT=0.
  - Scan state enum: IDLE, BLANK, DRIVE.
- **Sub-module `seg_hex_decode`:** combinational nibble→7-bit pattern, one instance on the muxed nibble.
- **Top level:** FSM, counters, registers and handshake stay in the top.

## Test plan

All cases use DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.

1. Reset, then `enable`=1, no write → 1 cycle idle, 2 cycles `dig_sel`=0, then `dig_sel`=0001 with `seg_out`=0x7E for 6 cycles. The pattern repeats for 0010/0100/1000. `frame_done` pulses every 32 cycles.
2. Write `wr_data`=0x12AF mid-frame → `wr_ready`=0 until the boundary. Next frame shows digit0=0x47, digit1=0x77, digit2=0x6D, digit3=0x30.
3. Write 0x0000 with `wr_dp`=4'b0100 → digit2 `seg_out`=0xFE, other digits 0x7E.
4. A second `wr_valid` held while pending → no accept until the cycle after `frame_done`. The value is then applied at the following boundary.
5. `enable`=0 during digit2 DRIVE → next cycle `dig_sel`=0 and `seg_out`=0. Re-enable → 2 blank cycles, then digit0.
6. With `SEG_SCAN_LEADING_ZERO_BLANK_EN`: 0x0005 → digits 3..1 show 0x00 and digit0 shows 0x5B. 0x0000 → digit0 shows 0x7E and the rest show 0x00.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment patterns, bit positions and scan state for seg_scan_ctrl
package seg_pkg;

    // Patterns are {a,b,c,d,e,f,g} in bits 6..0
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int SEG_DP_BIT = 7;
    localparam int SEG_A_BIT  = 6;
    localparam int SEG_B_BIT  = 5;
    localparam int SEG_C_BIT  = 4;
    localparam int SEG_D_BIT  = 3;
    localparam int SEG_E_BIT  = 2;
    localparam int SEG_F_BIT  = 1;
    localparam int SEG_G_BIT  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational hex nibble to 7-segment pattern
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-aligned updates
// Optional leading-zero suppression: define SEG_SCAN_LEADING_ZERO_BLANK_EN
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_dp,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int DRIVE_CYCLES = CLK_DIV - BLANK_CYCLES;
    localparam int CNT_W        = $clog2(CLK_DIV + 1);
    localparam int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);

    scan_state_e         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4*DIGITS-1:0] disp_data_q, pend_data_q;
    logic [DIGITS-1:0]   disp_dp_q, pend_dp_q;
    logic                pend_vld_q;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                frame_q, frame_d;

    logic                boundary;
    logic                accept;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic [6:0]          dec_seg;
    logic [6:0]          digit_seg;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // The last DRIVE cycle of the last digit is where pending data is committed
    assign boundary = (state_q == DRIVE) && (idx_q == LAST_IDX) && (cnt_q == DRIVE_LAST);
    assign accept   = wr_valid && !pend_vld_q;

    assign cur_nib = disp_data_q[{idx_d, 2'b00} +: 4];
    assign cur_dp  = disp_dp_q[idx_d];

    seg_hex_decode u_dec (
        .nibble_i (cur_nib),
        .seg_o    (dec_seg)
    );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lz_sup;
    logic              hi_nz;

    always_comb begin
        lz_sup = '0;
        hi_nz  = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            hi_nz     = hi_nz | (|disp_data_q[4*i +: 4]);
            lz_sup[i] = !hi_nz;
        end
    end

    assign digit_seg = lz_sup[idx_d] ? SEG_BLANK : dec_seg;
`else
    assign digit_seg = dec_seg;
`endif

    // Outputs are derived from next-state so the flops line up with the state
    always_comb begin
        seg_d   = '0;
        dig_d   = '0;
        frame_d = 1'b0;
        if (state_d == DRIVE) begin
            dig_d                       = DIGITS'(1) << idx_d;
            seg_d[SEG_DP_BIT]           = cur_dp;
            seg_d[SEG_A_BIT:SEG_G_BIT]  = digit_seg;
            frame_d                     = (idx_d == LAST_IDX) && (cnt_d == DRIVE_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_vld_q  <= 1'b0;
            seg_q       <= '0;
            dig_q       <= '0;
            frame_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
            if (accept) begin
                pend_data_q <= wr_data;
                pend_dp_q   <= wr_dp;
                pend_vld_q  <= 1'b1;
            end else if (boundary && pend_vld_q) begin
                disp_data_q <= pend_data_q;
                disp_dp_q   <= pend_dp_q;
                pend_vld_q  <= 1'b0;
            end
        end
    end

    assign wr_ready   = !pend_vld_q;
    assign seg_out    = seg_q;
    assign dig_sel    = dig_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank)
module tb_seg_scan_ctrl;

    localparam int DIGITS       = 4;
    localparam int CLK_DIV      = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int DRIVE_LEN    = CLK_DIV - BLANK_CYCLES;
    localparam int FRAME_LEN    = DIGITS * CLK_DIV;

    localparam logic [6:0] DEC_TAB [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef struct packed {
        logic [3:0] dig;
        logic [7:0] seg;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS       (DIGITS),
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    slot_t       exp_q[$];
    int          checks_total  = 0;
    int          checks_passed = 0;

    logic [15:0] disp_m     = 16'h0;
    logic [3:0]  disp_dp_m  = 4'h0;
    logic [15:0] pend_m     = 16'h0;
    logic [3:0]  pend_dp_m  = 4'h0;
    bit          pend_vld_m = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks_total++;
        if (ok) checks_passed++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] dp);
        for (int i = 0; i < DIGITS; i++) begin
            slot_t      s;
            logic [6:0] p;
            p = DEC_TAB[d[i*4 +: 4]];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
            if (i > 0 && (d >> (4 * i)) == 16'h0) p = 7'h00;
`endif
            s.dig = 4'(1 << i);
            s.seg = {dp[i], p};
            exp_q.push_back(s);
        end
    endtask

    task automatic wait_fd();
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check(1'b0, "frame_done_timeout", 0, 1);
    endtask

    task automatic wait_dig(input logic [3:0] want);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dig_sel == want) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check(1'b0, "dig_sel_timeout", 32'(dig_sel), 32'(want));
    endtask

    // Holds the offer until wr_ready is seen; reports whether frame_done was high the cycle before
    task automatic write_val(input logic [15:0] d, input logic [3:0] dp, output bit fd_before);
        bit got     = 1'b0;
        bit fd_last = 1'b0;
        fd_before = 1'b0;
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_dp    = dp;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                got       = 1'b1;
                fd_before = fd_last;
                break;
            end
            fd_last = frame_done;
        end
        if (!got) check(1'b0, "write_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        wr_valid   = 1'b0;
        pend_m     = d;
        pend_dp_m  = dp;
        pend_vld_m = 1'b1;
    endtask

    initial begin : producer
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && frame_done === 1'b1) begin
                if (pend_vld_m) begin
                    disp_m     = pend_m;
                    disp_dp_m  = pend_dp_m;
                    pend_vld_m = 1'b0;
                end
                push_frame(disp_m, disp_dp_m);
            end
        end
    end

    int         cyc = 0;
    logic [3:0] prev_dig = 4'h0;
    logic       en_prev = 1'b0;
    int         en_rise_cyc = 0;
    bit         startup_pending = 1'b0;
    int         slot_len = 0;
    logic [3:0] slot_dig = 4'h0;
    logic [7:0] slot_seg = 8'h0;
    bit         slot_stable = 1'b1;
    bit         slot_abort = 1'b0;
    bit         fd_ref_ok = 1'b0;
    int         fd_last_cyc = 0;

    initial begin : monitor
        slot_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n !== 1'b1) begin
                prev_dig  = 4'h0;
                en_prev   = 1'b0;
                fd_ref_ok = 1'b0;
            end else begin
                if (enable && !en_prev) begin
                    en_rise_cyc     = cyc;
                    startup_pending = 1'b1;
                end
                if (!enable) begin
                    fd_ref_ok = 1'b0;
                    if (dig_sel != 4'h0) slot_abort = 1'b1;
                end
                if (dig_sel != 4'h0) begin
                    if (prev_dig == 4'h0) begin
                        if (startup_pending) begin
                            check(cyc - en_rise_cyc == 3, "startup_latency", cyc - en_rise_cyc, 3);
                            startup_pending = 1'b0;
                        end
                        if (exp_q.size() == 0) begin
                            check(1'b0, "slot_unexpected", {dig_sel, seg_out}, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check(dig_sel == e.dig && seg_out == e.seg, "slot_pattern",
                                  {dig_sel, seg_out}, {e.dig, e.seg});
                        end
                        slot_len    = 1;
                        slot_dig    = dig_sel;
                        slot_seg    = seg_out;
                        slot_stable = 1'b1;
                        slot_abort  = !enable;
                    end else begin
                        slot_len++;
                        if (dig_sel != slot_dig || seg_out != slot_seg) slot_stable = 1'b0;
                    end
                    if (frame_done) begin
                        check(dig_sel == 4'b1000 && slot_len == DRIVE_LEN, "frame_done_pos",
                              {dig_sel, 8'(slot_len)}, {4'b1000, 8'(DRIVE_LEN)});
                        if (fd_ref_ok)
                            check(cyc - fd_last_cyc == FRAME_LEN, "frame_period", cyc - fd_last_cyc, FRAME_LEN);
                        fd_last_cyc = cyc;
                        fd_ref_ok   = 1'b1;
                    end
                end else begin
                    if (prev_dig != 4'h0 && !slot_abort)
                        check(slot_len == DRIVE_LEN && slot_stable && seg_out == 8'h0 && !frame_done,
                              "slot_hold", {slot_stable, seg_out, 8'(slot_len)}, {1'b1, 8'h0, 8'(DRIVE_LEN)});
                end
                prev_dig = dig_sel;
                en_prev  = enable;
            end
        end
    end

    initial begin : stimulus
        bit fd_b;
        rst_n    = 1'b0;
        enable   = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 16'h0;
        wr_dp    = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check(seg_out == 8'h0, "reset_seg_out", seg_out, 0);
        check(dig_sel == 4'h0, "reset_dig_sel", dig_sel, 0);
        check(frame_done == 1'b0, "reset_frame_done", frame_done, 0);
        check(wr_ready == 1'b1, "reset_wr_ready", wr_ready, 1);

        @(posedge clk);
        #1 enable = 1'b1;
        push_frame(disp_m, disp_dp_m);
        wait_fd();

        repeat (4) @(posedge clk);
        write_val(16'h12AF, 4'b0000, fd_b);
        @(negedge clk);
        check(wr_ready == 1'b0, "wr_ready_while_pending", wr_ready, 0);
        wait_fd();
        @(negedge clk);
        check(wr_ready == 1'b1, "wr_ready_after_boundary", wr_ready, 1);

        write_val(16'h0000, 4'b0100, fd_b);
        wait_fd();

        repeat (2) @(posedge clk);
        write_val(16'h3456, 4'b0001, fd_b);
        write_val(16'h789A, 4'b1000, fd_b);
        check(fd_b == 1'b1, "held_accept_after_frame_done", fd_b, 1);
        wait_fd();
        wait_fd();

        write_val(16'h0005, 4'b0000, fd_b);
        wait_fd();
        write_val(16'h0000, 4'b0000, fd_b);
        wait_fd();

        wait_dig(4'b0100);
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(dig_sel == 4'h0, "disable_dig_sel", dig_sel, 0);
        check(seg_out == 8'h0, "disable_seg_out", seg_out, 0);
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1 enable = 1'b1;
        push_frame(disp_m, disp_dp_m);
        wait_fd();
        wait_fd();

        @(posedge clk);
        #1 enable = 1'b0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
